// File: rtl/counter_button_conditioner.sv
// counter_button_conditioner: push-button front end for tt_um_counter.
// Two channels (sync + debounce + auto-repeat) feed a registered arbiter
// that never issues up and down pulses in the same cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           pulse enable (gates up_pulse, down_pulse, collision)
//   btn_up_raw   asynchronous raw up button, active high
//   btn_down_raw asynchronous raw down button, active high
//   up_pulse     one-cycle increment request
//   down_pulse   one-cycle decrement request
//   up_level     debounced up level
//   down_level   debounced down level
//   collision    up and down fired together, both dropped

module counter_button_channel #(
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
    localparam logic          HOLD_EN   = (HOLD_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    logic          ff1;
    logic          ff2;
    logic          db;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    state_t        state;

    logic accept;
    logic rise;
    logic fall;
    logic hold_hit;
    logic rep_hit;

    // The pulse is decided from the edge on which db is about to change,
    // so the press pulse lands on the same edge as the new level.
    always_comb begin
        accept   = (ff2 != db) && (dcnt == DEB_LAST);
        rise     = accept && ff2;
        fall     = accept && !ff2;
        hold_hit = HOLD_EN && (hcnt == HOLD_LAST);
        rep_hit  = (hcnt == REP_LAST);
        pulse    = 1'b0;
        case (state)
            IDLE:    pulse = rise;
            HELD:    pulse = !fall && hold_hit;
            REPEAT:  pulse = !fall && rep_hit;
            default: pulse = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1   <= 1'b0;
            ff2   <= 1'b0;
            db    <= 1'b0;
            dcnt  <= '0;
            hcnt  <= '0;
            state <= IDLE;
        end else begin
            ff1 <= raw;
            ff2 <= ff1;

            if (ff2 == db) begin
                dcnt <= '0;
            end else if (accept) begin
                db   <= ff2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end

            // A release (fall) always wins over a coinciding repeat.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HELD;
                        hcnt  <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state <= IDLE;
                        hcnt  <= '0;
                    end else if (hold_hit) begin
                        state <= REPEAT;
                        hcnt  <= '0;
                    end else if (HOLD_EN) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state <= IDLE;
                        hcnt  <= '0;
                    end else if (rep_hit) begin
                        hcnt <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

    assign level = db;

endmodule

module counter_button_conditioner #(
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_level,
    output logic down_level,
    output logic collision
);

    logic up_raw_pulse;
    logic down_raw_pulse;

    counter_button_channel #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up_raw),
        .level (up_level),
        .pulse (up_raw_pulse)
    );

    counter_button_channel #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_down (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_down_raw),
        .level (down_level),
        .pulse (down_raw_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            collision  <= 1'b0;
        end else begin
            up_pulse   <= en & up_raw_pulse & ~down_raw_pulse;
            down_pulse <= en & down_raw_pulse & ~up_raw_pulse;
            collision  <= en & up_raw_pulse & down_raw_pulse;
        end
    end

endmodule

// File: tb/tb_counter_button_conditioner.sv
// Testbench for counter_button_conditioner: edge-indexed reference model
// checked every cycle, plus directed scenarios with literal pulse positions.

module tb_counter_button_conditioner;

    localparam int M    = 4096;
    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic btn_up_raw;
    logic btn_down_raw;
    logic up_pulse;
    logic down_pulse;
    logic up_level;
    logic down_level;
    logic collision;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    counter_button_conditioner dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .up_pulse     (up_pulse),
        .down_pulse   (down_pulse),
        .up_level     (up_level),
        .down_level   (down_level),
        .collision    (collision)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: indexed by edge number. A level is accepted once the
    // synchronised sample (raw two edges earlier) has disagreed with the
    // debounced level on each of the last DEB edges since the last change.
    // Pulses are placed by elapsed time since the press.
    bit   rh [2][M];
    bit   sh [2][M];
    int   n = -1;
    int   rst_edge = 0;
    int   base [2];
    bit   mdb [2];
    bit   pressed [2];
    int   pe [2];
    bit   pl [2];
    bit   mvalid = 1'b0;
    logic e_up, e_dn, e_ul, e_dl, e_col;

    always @(posedge clk) begin
        bit r [2];
        bit s;
        bit acc;
        int t;
        n++;
        r[0] = btn_up_raw;
        r[1] = btn_down_raw;
        if (rst) begin
            rst_edge = n;
            mvalid   = 1'b1;
            for (int c = 0; c < 2; c++) begin
                base[c]    = n;
                mdb[c]     = 1'b0;
                pressed[c] = 1'b0;
                pl[c]      = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                rh[c][n % M] = r[c];
                s = (n - 2 > rst_edge) ? rh[c][(n - 2) % M] : 1'b0;
                sh[c][n % M] = s;
                acc = (n - base[c] >= DEB);
                for (int k = 0; k < DEB; k++)
                    if (sh[c][(n - k) % M] == mdb[c]) acc = 1'b0;
                pl[c] = 1'b0;
                if (acc) begin
                    mdb[c]  = ~mdb[c];
                    base[c] = n;
                    if (mdb[c]) begin
                        pressed[c] = 1'b1;
                        pe[c]      = n;
                        pl[c]      = 1'b1;
                    end else begin
                        pressed[c] = 1'b0;
                    end
                end else if (pressed[c] && HOLD > 0) begin
                    t = n - pe[c];
                    if (t >= HOLD && ((t - HOLD) % REP) == 0)
                        pl[c] = 1'b1;
                end
            end
        end
        e_up  = !rst && en && pl[0] && !pl[1];
        e_dn  = !rst && en && pl[1] && !pl[0];
        e_col = !rst && en && pl[0] && pl[1];
        e_ul  = mdb[0];
        e_dl  = mdb[1];
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("model_up_pulse", up_pulse, e_up);
            check("model_down_pulse", down_pulse, e_dn);
            check("model_collision", collision, e_col);
            check("model_up_level", up_level, e_ul);
            check("model_down_level", down_level, e_dl);
        end
    end

    int pu[$];
    int pd[$];
    int pc[$];
    int eq[$];
    int ur, uf, dr, df;

    task automatic check_q(input string name, input int got[$],
                           input int exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, got[i], exp[i]);
    endtask

    // Index i in the capture lists is the edge Ei, E0 being the first edge
    // that samples the new raw value.
    task automatic press(input int hold, input int total, input logic u,
                         input logic d, input logic bounce);
        logic v;
        pu.delete();
        pd.delete();
        pc.delete();
        ur = -1; uf = -1; dr = -1; df = -1;
        for (int i = 0; i < total; i++) begin
            v = (i < hold) && (!bounce || i >= 12 || ((i / 2) % 2) == 0);
            btn_up_raw   = v & u;
            btn_down_raw = v & d;
            @(negedge clk);
            if (up_pulse)   pu.push_back(i);
            if (down_pulse) pd.push_back(i);
            if (collision)  pc.push_back(i);
            if (ur < 0 && up_level) ur = i;
            if (ur >= 0 && uf < 0 && !up_level) uf = i;
            if (dr < 0 && down_level) dr = i;
            if (dr >= 0 && df < 0 && !down_level) df = i;
        end
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
    endtask

    initial begin
        int nz;
        rst          = 1'b1;
        en           = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_up_pulse", up_pulse, 0);
        check("rst_down_pulse", down_pulse, 0);
        check("rst_collision", collision, 0);
        check("rst_up_level", up_level, 0);
        check("rst_down_level", down_level, 0);
        rst = 1'b0;
        nz  = 0;
        repeat (10) begin
            @(negedge clk);
            nz += int'(up_pulse) + int'(down_pulse) + int'(collision)
                + int'(up_level) + int'(down_level);
        end
        check("post_rst_quiet", nz, 0);

        // Clean press
        press(14, 30, 1'b1, 1'b0, 1'b0);
        eq = '{5};
        check_q("clean_up_pos", pu, eq);
        check("clean_up_rise", ur, 5);
        check("clean_up_fall", uf, 19);
        check("clean_down_cnt", pd.size(), 0);

        // Bounce
        press(26, 40, 1'b1, 1'b0, 1'b1);
        eq = '{17};
        check_q("bounce_up_pos", pu, eq);
        check("bounce_up_rise", ur, 17);
        check("bounce_up_fall", uf, 31);

        // Auto-repeat
        press(60, 80, 1'b0, 1'b1, 1'b0);
        eq = '{5, 21, 29, 37, 45, 53, 61};
        check_q("repeat_down_pos", pd, eq);
        check("repeat_down_rise", dr, 5);
        check("repeat_down_fall", df, 65);
        check("repeat_up_cnt", pu.size(), 0);

        // Collision
        press(30, 45, 1'b1, 1'b1, 1'b0);
        eq = '{5, 21, 29};
        check_q("coll_pos", pc, eq);
        check("coll_up_cnt", pu.size(), 0);
        check("coll_down_cnt", pd.size(), 0);
        check("coll_up_rise", ur, 5);
        check("coll_down_rise", dr, 5);
        check("coll_up_fall", uf, 35);

        // Enable low
        en = 1'b0;
        press(10, 25, 1'b1, 1'b0, 1'b0);
        check("en0_up_cnt", pu.size(), 0);
        check("en0_up_rise", ur, 5);
        check("en0_up_fall", uf, 15);
        en = 1'b1;

        // Reset while in REPEAT with the button still held
        btn_up_raw = 1'b1;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_up_pulse", up_pulse, 0);
        check("rst_mid_up_level", up_level, 0);
        check("rst_mid_collision", collision, 0);
        @(negedge clk);
        rst = 1'b0;
        pu.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (up_pulse) pu.push_back(i);
        end
        eq = '{5};
        check_q("rst_mid_repress_pos", pu, eq);
        btn_up_raw = 1'b0;
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
